spmm_out_collector: RTL

Output-side collector for the SpMM PE array. It captures one N-element result row per valid beat from the N PEs into an N×N output buffer. With the accumulate feature compiled in, it can add each new row into the stored output for output-stationary operation. Once N rows are stored, it drains the matrix to the SpMM output port as N/4 beats of 4 rows each, under the out_ready/out_start handshake.

---
 rtl/spmm_out_collector.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spmm_out_collector.sv
// Output collector for the SpMM PE array: gathers N result rows into an NxN buffer, then drains 4 rows per beat.
// Optional macro OS_ACCUM_EN builds the output-stationary accumulate path (row += stored row).
module spmm_out_collector #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         row_valid,
  input  logic [N-1:0][W-1:0]          row_data,
  input  logic                         row_accum,
  output logic                         in_ready,
  output logic                         overflow,
  output logic                         out_ready,
  input  logic                         out_start,
  output logic [3:0][N-1:0][W-1:0]     out_data
);

  localparam int RW = $clog2(N);
  localparam int NB = N / 4;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                      state_r;
  logic [RW-1:0]               row_cnt_r;
  logic [BW-1:0]               beat_cnt_r;
  logic                        overflow_r;
  logic [N-1:0][N-1:0][W-1:0]  mem_r;

  logic                        row_take_s;
  logic                        start_take_s;
  logic [N-1:0][W-1:0]         row_next_s;
  logic [BW-1:0]               beat_s;

  // Handshake decodes straight from the registered state.
  always_comb begin
    in_ready     = (state_r == EMPTY) || (state_r == FILL);
    out_ready    = (state_r == FULL);
    overflow     = overflow_r;
    row_take_s   = row_valid && in_ready;
    start_take_s = out_start && (state_r == FULL);
  end

`ifdef OS_ACCUM_EN
  logic accum_r;
  logic accum_sel_s;

  // The first row of a matrix uses row_accum directly; later rows use the latched mode.
  always_comb begin
    accum_sel_s = (state_r == EMPTY) ? row_accum : accum_r;
  end

  // New row value: element-wise modulo-2^W sum or plain overwrite.
  always_comb begin
    row_next_s = '0;
    for (int j = 0; j < N; j++) begin
      if (accum_sel_s) begin
        row_next_s[j] = mem_r[row_cnt_r][j] + row_data[j];
      end else begin
        row_next_s[j] = row_data[j];
      end
    end
  end
`else
  logic unused_accum_s;

  // Without the accumulate path every accepted row overwrites.
  always_comb begin
    unused_accum_s = row_accum;
    row_next_s     = row_data;
  end
`endif

  // Collector FSM, row buffer and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= EMPTY;
      row_cnt_r  <= '0;
      beat_cnt_r <= '0;
      overflow_r <= 1'b0;
      mem_r      <= '0;
`ifdef OS_ACCUM_EN
      accum_r    <= 1'b0;
`endif
    end else begin
      if (row_valid && !in_ready) begin
        overflow_r <= 1'b1;
      end
      if (row_take_s) begin
        mem_r[row_cnt_r] <= row_next_s;
        row_cnt_r        <= row_cnt_r + {{(RW-1){1'b0}}, 1'b1};
      end
      case (state_r)
        EMPTY: begin
          if (row_take_s) begin
            state_r <= FILL;
`ifdef OS_ACCUM_EN
            accum_r <= row_accum;
`endif
          end
        end
        FILL: begin
          if (row_take_s && (row_cnt_r == RW'(N - 1))) begin
            state_r <= FULL;
          end
        end
        FULL: begin
          // Beat 0 leaves in the start cycle itself, so DRAIN resumes at beat 1.
          if (out_start) begin
            if (NB == 1) begin
              state_r    <= EMPTY;
              beat_cnt_r <= '0;
            end else begin
              state_r    <= DRAIN;
              beat_cnt_r <= BW'(1);
            end
          end
        end
        DRAIN: begin
          if (beat_cnt_r == BW'(NB - 1)) begin
            state_r    <= EMPTY;
            beat_cnt_r <= '0;
          end else begin
            beat_cnt_r <= beat_cnt_r + {{(BW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

  // Drain read port: zero-latency so beat 0 is visible in the out_start cycle.
  always_comb begin
    out_data = '0;
    beat_s   = (state_r == DRAIN) ? beat_cnt_r : '0;
    if ((state_r == DRAIN) || start_take_s) begin
      for (int i = 0; i < 4; i++) begin
        out_data[i] = mem_r[RW'(4 * int'(beat_s) + i)];
      end
    end else begin
      out_data = '0;
    end
  end

endmodule
